approx_log_divider_pipe: RTL and testbench
==========================================

Name: approx_log_divider_pipe

Overview:
- Pipelined Mitchell-style approximate log-domain divider; the inverse datapath of the approximate log multiplier.
- Takes a signed product-width numerator and a signed factor-width denominator, and recovers an approximate signed quotient.
- Uses leading-one detection, log-domain subtraction and an antilog shift.
- Sits behind a valid/ready source, feeds a valid/ready sink, and is used for accuracy sweeps alongside the multiplier.

Parameters:
- NUM_W, 16, numerator and quotient width (signed).
- DEN_W, 8, denominator width (signed).
- FRAC_W, 15, log-fraction width; must equal NUM_W-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept operands this cycle.
- num  in  NUM_W  signed dividend.
- den  in  DEN_W  signed divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- quo  out  NUM_W  signed approximate quotient, truncated toward zero.
- dz  out  1  divide-by-zero flag, qualified by out_valid.
- ovf  out  1  saturation flag, qualified by out_valid.

Behaviour:
- Reset: all stage valids, out_valid, quo, dz and ovf go to 0 immediately on rst_n low. in_ready is 1 while in reset-released idle.
- Reset mid-operation discards all in-flight items; no output is produced for them.
- Pipeline: 3 stages, global advance = !out_valid || out_ready, and in_ready = advance.
  - An operand is accepted on in_valid && in_ready.
  - Its result appears with out_valid exactly 3 cycles later when there is no stall.
  - Bubbles are not compressed.
  - While stalled, quo, dz, ovf and out_valid hold stable.
- S1: sign = num[MSB] ^ den[MSB].
  - Magnitudes a (NUM_W unsigned) and b (DEN_W unsigned); |-32768| = 32768 is legal.
  - ka and kb are the leading-one positions.
  - fa = bits below the leading one of a, left-aligned to FRAC_W.
  - fb = same for b, left-aligned to FRAC_W.
  - zero flags az and bz are registered.
- S2: if fa >= fb, then k = ka-kb and f = fa-fb. Otherwise (borrow) k = ka-kb-1 and f = fa-fb+2^FRAC_W, truncated to FRAC_W. k is signed, range -8..15.
- S3: if k < 0, mag = 0. Otherwise mag = ({1,f} >> (FRAC_W-k)), giving 17 bits.
  - Apply sign.
  - If positive and mag > 32767: quo = 32767, ovf = 1.
  - If negative and mag > 32768: quo = -32768, ovf = 1.
- Special cases, decided in S3 with priority bz over az:
  - den == 0: dz = 1; quo = 32767 if num > 0, -32768 if num < 0, 0 if num == 0.
  - num == 0 (den != 0): quo = 0, dz = 0, ovf = 0.
- The result is exact whenever |den| is a power of two (truncated toward zero).

Optional Feature:
- Macro ALD_CORRECTION_EN.
- Defined: in the S2 borrow case only, subtract 2^(FRAC_W-3) (value 1/8, 15'h1000) from f, floored at 0. This reduces Mitchell overestimation.
- Undefined: plain Mitchell, no correction logic present.
- Non-borrow cases are identical in both builds.

Decomposition:
- Package approx_div_pkg holds:
  - NUM_W, DEN_W, FRAC_W defaults.
  - The correction constant.
  - Packed stage structs s1_t (sign, az, bz, ka, kb, fa, fb) and s2_t (sign, az, bz, k, f).
  - Saturation limits.
- One sub-module, approx_lod: parameterized leading-one detector returning position and left-aligned fraction. It is instantiated twice in S1.

Test Plan:
- num=100, den=4 -> quo=25, dz=0, ovf=0; out_valid exactly 3 cycles after acceptance.
- num=-96, den=3 -> quo=-32. num=100, den=3 -> quo=34 in both builds (no borrow).
- num=64, den=3 (borrow) -> quo=24 without ALD_CORRECTION_EN, 22 with it.
- num=-32768, den=-1 -> quo=32767, ovf=1. num=500, den=0 -> quo=32767, dz=1. num=0, den=0 -> quo=0, dz=1. num=5, den=7 -> quo=0.
- Back-to-back 5 operands with out_ready low for 6 cycles -> in_ready low after 3 accepted; quo/out_valid held stable; all 5 results delivered in order once out_ready returns.
- Assert rst_n low while 2 items are in flight -> out_valid drops to 0 asynchronously; no stale results appear after release.

Source files
------------

// File: rtl/approx_div_pkg.sv
// Shared widths, constants and stage records for the approximate log-domain divider.
// The ALD_CORRECTION_EN build option only changes logic in approx_log_divider_pipe.
package approx_div_pkg;

  localparam int ALD_NUM_W  = 16;
  localparam int ALD_DEN_W  = 8;
  localparam int ALD_FRAC_W = ALD_NUM_W - 1;

  localparam int ALD_KA_W = $clog2(ALD_NUM_W);
  localparam int ALD_KB_W = $clog2(ALD_DEN_W);
  // One extra bit so ka-kb-1 can go negative (-8..15).
  localparam int ALD_K_W  = ALD_KA_W + 1;
  localparam int ALD_SH_W = $clog2(ALD_FRAC_W + 1);

  // 1/8 in log-fraction units, applied only when the fraction subtraction borrows.
  localparam logic [ALD_FRAC_W-1:0] ALD_CORR = 15'h1000;

  localparam logic [ALD_NUM_W-1:0] ALD_QUO_MAX = 16'h7FFF;
  localparam logic [ALD_NUM_W-1:0] ALD_QUO_MIN = 16'h8000;
  localparam logic [ALD_NUM_W:0]   ALD_MAG_POS_MAX = 17'h07FFF;
  localparam logic [ALD_NUM_W:0]   ALD_MAG_NEG_MAX = 17'h08000;

  typedef struct packed {
    logic                  sign;
    logic                  az;
    logic                  bz;
    logic [ALD_KA_W-1:0]   ka;
    logic [ALD_KB_W-1:0]   kb;
    logic [ALD_FRAC_W-1:0] fa;
    logic [ALD_FRAC_W-1:0] fb;
  } s1_t;

  typedef struct packed {
    logic                       sign;
    logic                       az;
    logic                       bz;
    logic signed [ALD_K_W-1:0]  k;
    logic [ALD_FRAC_W-1:0]      f;
  } s2_t;

endpackage

// File: rtl/approx_lod.sv
// Leading-one detector: returns the position of the highest set bit and the bits
// below it left-aligned to FRAC_W. Requires W <= FRAC_W+1.
module approx_lod #(
  parameter int W      = 16,
  parameter int FRAC_W = 15
) (
  input  logic [W-1:0]         i_x,
  output logic [$clog2(W)-1:0] o_pos,
  output logic [FRAC_W-1:0]    o_frac,
  output logic                 o_zero
);

  localparam int PW = $clog2(W);
  localparam int SW = $clog2(FRAC_W + 1);

  logic [FRAC_W:0] w_ext;
  logic [SW-1:0]   w_shamt;

  always_comb begin
    o_pos = '0;
    for (int i = 0; i < W; i++) begin
      if (i_x[i]) o_pos = PW'(i);
    end
  end

  // Shifting the leading one up to bit FRAC_W drops it and leaves the fraction below.
  assign w_ext   = (FRAC_W + 1)'(i_x);
  assign w_shamt = SW'(FRAC_W) - SW'(o_pos);
  assign o_frac  = FRAC_W'(w_ext << w_shamt);
  assign o_zero  = ~|i_x;

endmodule

// File: rtl/approx_log_divider_pipe.sv
// Three-stage Mitchell approximate divider: LOD, log subtraction, antilog + saturation.
// Define ALD_CORRECTION_EN to subtract 1/8 from the log fraction on borrow.
module approx_log_divider_pipe
  import approx_div_pkg::*;
#(
  parameter int NUM_W  = ALD_NUM_W,
  parameter int DEN_W  = ALD_DEN_W,
  parameter int FRAC_W = ALD_FRAC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NUM_W-1:0] quo,
  output logic             dz,
  output logic             ovf
);

  logic w_advance;

  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  // ---------------- S1: magnitudes and leading-one detection ----------------
  logic [NUM_W-1:0]      w_a;
  logic [DEN_W-1:0]      w_b;
  logic [ALD_KA_W-1:0]   w_ka;
  logic [ALD_KB_W-1:0]   w_kb;
  logic [ALD_FRAC_W-1:0] w_fa;
  logic [ALD_FRAC_W-1:0] w_fb;
  logic                  w_az;
  logic                  w_bz;
  s1_t                   w_s1;
  s1_t                   r_s1;
  logic                  r_s1_valid;

  // |-32768| wraps to 16'h8000, which is the correct unsigned magnitude.
  assign w_a = num[NUM_W-1] ? (~num + NUM_W'(1)) : num;
  assign w_b = den[DEN_W-1] ? (~den + DEN_W'(1)) : den;

  approx_lod #(.W(NUM_W), .FRAC_W(ALD_FRAC_W)) u_lod_a (
    .i_x    (w_a),
    .o_pos  (w_ka),
    .o_frac (w_fa),
    .o_zero (w_az)
  );

  approx_lod #(.W(DEN_W), .FRAC_W(ALD_FRAC_W)) u_lod_b (
    .i_x    (w_b),
    .o_pos  (w_kb),
    .o_frac (w_fb),
    .o_zero (w_bz)
  );

  always_comb begin
    w_s1      = '0;
    w_s1.sign = num[NUM_W-1] ^ den[DEN_W-1];
    w_s1.az   = w_az;
    w_s1.bz   = w_bz;
    w_s1.ka   = w_ka;
    w_s1.kb   = w_kb;
    w_s1.fa   = w_fa;
    w_s1.fb   = w_fb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      r_s1       <= w_s1;
    end
  end

  // ---------------- S2: log-domain subtraction ----------------
  logic                  w_borrow;
  logic [ALD_FRAC_W-1:0] w_f_raw;
  logic [ALD_FRAC_W-1:0] w_f;
  s2_t                   w_s2;
  s2_t                   r_s2;
  logic                  r_s2_valid;

  assign w_borrow = r_s1.fa < r_s1.fb;
  // Modular subtraction already yields fa-fb+2^FRAC_W on borrow.
  assign w_f_raw  = r_s1.fa - r_s1.fb;

`ifdef ALD_CORRECTION_EN
  always_comb begin
    w_f = w_f_raw;
    if (w_borrow) w_f = (w_f_raw >= ALD_CORR) ? (w_f_raw - ALD_CORR) : '0;
  end
`else
  assign w_f = w_f_raw;
`endif

  always_comb begin
    w_s2      = '0;
    w_s2.sign = r_s1.sign;
    w_s2.az   = r_s1.az;
    w_s2.bz   = r_s1.bz;
    w_s2.k    = {1'b0, r_s1.ka} - ALD_K_W'(r_s1.kb) - ALD_K_W'(w_borrow);
    w_s2.f    = w_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      r_s2       <= w_s2;
    end
  end

  // ---------------- S3: antilog, sign, saturation, special cases ----------------
  logic [ALD_SH_W-1:0] w_shamt;
  logic [NUM_W:0]      w_mag;
  logic [NUM_W-1:0]    w_quo;
  logic                w_dz;
  logic                w_ovf;
  logic                r_out_valid;
  logic [NUM_W-1:0]    r_quo;
  logic                r_dz;
  logic                r_ovf;

  assign w_shamt = ALD_SH_W'(FRAC_W) - r_s2.k[ALD_SH_W-1:0];
  assign w_mag   = r_s2.k[ALD_K_W-1] ? '0 : ({2'b01, r_s2.f} >> w_shamt);

  // A zero divisor wins over a zero dividend.
  always_comb begin
    w_quo = '0;
    w_dz  = 1'b0;
    w_ovf = 1'b0;
    if (r_s2.bz) begin
      w_dz = 1'b1;
      if (!r_s2.az) w_quo = r_s2.sign ? ALD_QUO_MIN : ALD_QUO_MAX;
    end else if (!r_s2.az) begin
      if (!r_s2.sign) begin
        if (w_mag > ALD_MAG_POS_MAX) begin
          w_quo = ALD_QUO_MAX;
          w_ovf = 1'b1;
        end else begin
          w_quo = w_mag[NUM_W-1:0];
        end
      end else begin
        if (w_mag > ALD_MAG_NEG_MAX) begin
          w_quo = ALD_QUO_MIN;
          w_ovf = 1'b1;
        end else begin
          w_quo = -w_mag[NUM_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_quo       <= '0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_quo <= w_quo;
        r_dz  <= w_dz;
        r_ovf <= w_ovf;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign quo       = r_quo;
  assign dz        = r_dz;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_approx_log_divider_pipe.sv
// Self-checking bench for approx_log_divider_pipe: directed cases, stall, async reset,
// then randomized traffic against a log-arithmetic reference model.
module tb_approx_log_divider_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] num = '0;
  logic [7:0]  den = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] quo;
  logic        dz;
  logic        ovf;

  always #5 clk = ~clk;

  approx_log_divider_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .den       (den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quo       (quo),
    .dz        (dz),
    .ovf       (ovf)
  );

  typedef struct {
    int q;
    bit dz;
    bit ovf;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          fire_in;
  bit          fire_out;
  int          n_del = 0;
  logic        s_ov;
  logic [15:0] s_quo;
  logic        s_dz;
  logic        s_ovf;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Mitchell division in plain integer log arithmetic (fraction scaled by 2^15).
  function automatic void model(input int n, input int d, output int q, output bit mdz, output bit movf);
    int a, b, ka, kb, fa, fb, ld, k, f, mag;
    bit neg;
    q = 0; mdz = 0; movf = 0;
    if (d == 0) begin
      mdz = 1;
      q = (n > 0) ? 32767 : ((n < 0) ? -32768 : 0);
      return;
    end
    if (n == 0) return;
    a = (n < 0) ? -n : n;
    b = (d < 0) ? -d : d;
    ka = 0; while ((2 << ka) <= a) ka++;
    kb = 0; while ((2 << kb) <= b) kb++;
    fa = (a - (1 << ka)) << (15 - ka);
    fb = (b - (1 << kb)) << (15 - kb);
    ld = (ka * 32768 + fa) - (kb * 32768 + fb);
    k  = ld >>> 15;
    f  = ld - k * 32768;
`ifdef ALD_CORRECTION_EN
    if (fa < fb) f = (f >= 4096) ? (f - 4096) : 0;
`endif
    mag = (k < 0) ? 0 : (((32768 + f) << k) >> 15);
    neg = (n < 0) != (d < 0);
    if (!neg) begin
      if (mag > 32767) begin q = 32767; movf = 1; end
      else q = mag;
    end else begin
      if (mag > 32768) begin q = -32768; movf = 1; end
      else q = -mag;
    end
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    fire_in  = in_valid && in_ready;
    fire_out = out_valid && out_ready;
    s_ov = out_valid; s_quo = quo; s_dz = dz; s_ovf = ovf;
    if (fire_in) begin
      model(int'($signed(num)), int'($signed(den)), e.q, e.dz, e.ovf);
      sb.push_back(e);
    end
    if (fire_out) begin
      n_del++;
      check("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_quo", $signed(quo), e.q);
        check("sb_dz", dz, e.dz);
        check("sb_ovf", ovf, e.ovf);
        $display("txn num=%0d den=%0d? quo=%0d dz=%0d ovf=%0d", 0, 0, $signed(quo), dz, ovf);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_one(input string tag, input int n, input int d, input int eq, input bit edz, input bit eovf);
    int lat;
    bit got;
    num = 16'(n); den = 8'(d); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check({tag, "_accept"}, fire_in, 1);
    in_valid = 1'b0;
    lat = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      lat++;
      got = s_ov;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_quo"}, $signed(s_quo), eq);
    check({tag, "_dz"}, s_dz, edz);
    check({tag, "_ovf"}, s_ovf, eovf);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_n[5];
    int stall_d[5];
    int idx;
    int del0;
    int stale;
    logic [15:0] ref_quo;
    bit have_ref;

    stall_n = '{11, -2000, 777, 32000, -5};
    stall_d = '{3, 7, -4, 2, 9};

    // Reset state
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_quo", quo, 0);
    check("rst_dz", dz, 0);
    check("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);

    // Directed cases
    send_one("div_100_4", 100, 4, 25, 0, 0);
    send_one("div_m96_3", -96, 3, -32, 0, 0);
    send_one("div_100_3", 100, 3, 34, 0, 0);
`ifdef ALD_CORRECTION_EN
    send_one("div_64_3", 64, 3, 22, 0, 0);
`else
    send_one("div_64_3", 64, 3, 24, 0, 0);
`endif
    send_one("div_m32768_m1", -32768, -1, 32767, 0, 1);
    send_one("div_500_0", 500, 0, 32767, 1, 0);
    send_one("div_m500_0", -500, 0, -32768, 1, 0);
    send_one("div_0_0", 0, 0, 0, 1, 0);
    send_one("div_0_5", 0, 5, 0, 0, 0);
    send_one("div_5_7", 5, 7, 0, 0, 0);
    send_one("div_m1000_m8", -1000, -8, 125, 0, 0);

    // Back-to-back with the sink stalled for 6 cycles
    out_ready = 1'b0;
    idx = 0; have_ref = 0;
    num = 16'(stall_n[0]); den = 8'(stall_d[0]); in_valid = 1'b1;
    del0 = n_del;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (fire_in) idx++;
      if (s_ov) begin
        if (!have_ref) begin
          ref_quo = s_quo;
          have_ref = 1;
        end else begin
          check("stall_quo_hold", s_quo, ref_quo);
          check("stall_valid_hold", s_ov, 1);
        end
      end
      if (idx < 5) begin num = 16'(stall_n[idx]); den = 8'(stall_d[idx]); end
      else in_valid = 1'b0;
    end
    check("stall_accepted", idx, 3);
    check("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 30 && (n_del - del0) < 5; c++) begin
      tick();
      if (fire_in) idx++;
      if (idx < 5) begin num = 16'(stall_n[idx]); den = 8'(stall_d[idx]); end
      else in_valid = 1'b0;
    end
    check("stall_delivered", n_del - del0, 5);

    // Asynchronous reset with two items in flight
    out_ready = 1'b0;
    num = 16'd900; den = 8'd5; in_valid = 1'b1;
    tick();
    num = 16'd901; den = 8'd6;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_rst_out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_quo", quo, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (s_ov) stale++;
    end
    check("no_stale_after_rst", stale, 0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      int r;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 7);
      num = 16'($urandom);
      if (r == 0) num = '0;
      if (r == 1) num = 16'($urandom_range(0, 600));
      case ($urandom_range(0, 7))
        0:       den = '0;
        1, 2:    den = 8'(($urandom_range(0, 1) ? -1 : 1) * (1 << $urandom_range(0, 6)));
        default: den = 8'($urandom);
      endcase
      tick();
    end

    // Drain
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) tick();
    check("drain_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
